// File: rtl/uart_line_packer_pkg.sv
// Shared DRAM line definitions for the UART write path: line geometry, address widths, FSM states.
// The MIG wrapper and the read-side separator use the same defaults.
package uart_line_packer_pkg;
  localparam int unsigned LINE_BYTES_DEF  = 64;
  localparam int unsigned LINE_W_DEF      = 8 * LINE_BYTES_DEF;
  localparam int unsigned TAG_W_DEF       = 18;
  localparam int unsigned INDEX_W_DEF     = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;

  typedef enum logic {
    FILL  = 1'b0,
    WRITE = 1'b1
  } state_t;
endpackage

// File: rtl/uart_line_packer_if.sv
// Byte-in / line-write-out bundle between UART RX, the line packer and the MIG wrapper.
interface uart_line_packer_if
  import uart_line_packer_pkg::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned INDEX_W = INDEX_W_DEF
);
  logic [7:0]         din;
  logic               din_valid;
  logic               write_L2_MEM;
  logic [LINE_W-1:0]  write_data_L2_MEM;
  logic [TAG_W-1:0]   tag_o;
  logic [INDEX_W-1:0] index_o;
  logic               ready_MEM_L2;
  logic               busy_o;
  logic               overflow_o;
  logic               timeout_o;
  logic [3:0]         lines_o;

  modport master (
    output din, din_valid, ready_MEM_L2,
    input  write_L2_MEM, write_data_L2_MEM, tag_o, index_o,
           busy_o, overflow_o, timeout_o, lines_o
  );

  modport slave (
    input  din, din_valid, ready_MEM_L2,
    output write_L2_MEM, write_data_L2_MEM, tag_o, index_o,
           busy_o, overflow_o, timeout_o, lines_o
  );
endinterface

// File: rtl/uart_line_packer_idle_timer.sv
// Idle cycle counter: pulses expire on the TIMEOUT_CYC-th consecutive enabled cycle since clear.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

      logic [CW-1:0] cnt;

      // Expiry is decoded one count early so it fires in the cycle the count would reach the limit.
      assign expire = enable && (cnt == LIMIT);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt <= '0;
        end else if (!enable || clear || expire) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate
endmodule

// File: rtl/uart_line_packer.sv
// Packs UART bytes MSB-first into DRAM lines and issues one write per full line, with
// auto-incrementing {tag,index} address, sticky drop/timeout flags and a line counter.
module uart_line_packer
  import uart_line_packer_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = LINE_BYTES_DEF,
  parameter int unsigned TAG_W       = TAG_W_DEF,
  parameter int unsigned INDEX_W     = INDEX_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic             clk,
  input logic             rstn,
  uart_line_packer_if.slave bus
);
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned CNT_W  = $clog2(LINE_BYTES);
  localparam int unsigned ADDR_W = TAG_W + INDEX_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_BYTES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [LINE_W-1:0]  line_buf;
  logic [ADDR_W-1:0]  addr;
  logic [3:0]         lines;
  logic               overflow, timeout;
  logic               store, drop, done, expire, timer_en;

  assign timer_en = (state == FILL) && (count != '0);

  idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (bus.din_valid),
    .enable (timer_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store     = 1'b0;
    drop      = 1'b0;
    done      = 1'b0;
    unique case (state)
      FILL: begin
        store = bus.din_valid;
        // An expiring line restarts at byte 0, so the incoming byte can never complete it.
        if (store && !expire && (count == LAST)) state_nxt = WRITE;
      end
      WRITE: begin
        drop = bus.din_valid;
        if (bus.ready_MEM_L2) begin
          done      = 1'b1;
          state_nxt = FILL;
        end
      end
    endcase
  end

  // Shifting in at the bottom leaves byte 0 in the top lane once the line is full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= '0;
      line_buf <= '0;
      addr     <= '0;
      lines    <= '0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (expire) begin
        timeout  <= 1'b1;
        count    <= store ? CNT_W'(1) : '0;
        line_buf <= store ? LINE_W'(bus.din) : '0;
      end else if (store) begin
        count    <= (count == LAST) ? '0 : count + CNT_W'(1);
        line_buf <= {line_buf[LINE_W-9:0], bus.din};
      end
      if (drop) overflow <= 1'b1;
      if (done) begin
        addr  <= addr + ADDR_W'(1);
        lines <= lines + 4'd1;
      end
    end
  end

  assign bus.write_L2_MEM      = (state == WRITE);
  assign bus.busy_o            = (state == WRITE);
  assign bus.write_data_L2_MEM = line_buf;
  assign bus.tag_o             = addr[ADDR_W-1 -: TAG_W];
  assign bus.index_o           = addr[INDEX_W-1:0];
  assign bus.overflow_o        = overflow;
  assign bus.timeout_o         = timeout;
  assign bus.lines_o           = lines;
endmodule

// File: tb/tb_uart_line_packer.sv
// Directed bench for uart_line_packer: line assembly, write handshake, drops, timeout, wrap, reset.
module tb_uart_line_packer;
  localparam int unsigned LB = 64;
  localparam int unsigned TW = 2;
  localparam int unsigned IW = 3;
  localparam int unsigned TO = 100;
  localparam int unsigned DW = 8 * LB;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_line_packer_if #(.LINE_W(DW), .TAG_W(TW), .INDEX_W(IW)) bus ();

  uart_line_packer #(
    .LINE_BYTES  (LB),
    .TAG_W       (TW),
    .INDEX_W     (IW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_line(input logic [7:0] seed);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LB); k++) v[8*(int'(LB)-k)-1 -: 8] = seed + 8'(k);
    return v;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.din       = b;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    bus.ready_MEM_L2 = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_MEM_L2 = 1'b0;
  endtask

  task automatic fill_line(input logic [7:0] seed);
    for (int k = 0; k < int'(LB) - 1; k++) send_byte(seed + 8'(k));
    check_eq("wr_early", 512'(bus.write_L2_MEM), 512'(0));
    send_byte(seed + 8'(LB - 1));
    check_eq("wr_full", 512'(bus.write_L2_MEM), 512'(1));
  endtask

  task automatic do_line(input logic [7:0] seed);
    fill_line(seed);
    pulse_ready();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.din          = '0;
    bus.din_valid    = 1'b0;
    bus.ready_MEM_L2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr",    512'(bus.write_L2_MEM), 512'(0));
    check_eq("rst_data",  bus.write_data_L2_MEM,  512'(0));
    check_eq("rst_tag",   512'(bus.tag_o),        512'(0));
    check_eq("rst_idx",   512'(bus.index_o),      512'(0));
    check_eq("rst_flags", 512'({bus.busy_o, bus.overflow_o, bus.timeout_o}), 512'(0));
    check_eq("rst_lines", 512'(bus.lines_o),      512'(0));
    rstn = 1'b1;
    idle(2);

    // 1: slow line 00..3F, late acknowledge
    for (int k = 0; k < int'(LB) - 1; k++) begin
      send_byte(8'(k));
      idle(10);
    end
    check_eq("t1_wr_before", 512'(bus.write_L2_MEM), 512'(0));
    send_byte(8'h3F);
    check_eq("t1_wr",     512'(bus.write_L2_MEM), 512'(1));
    check_eq("t1_busy",   512'(bus.busy_o), 512'(1));
    check_eq("t1_data",   bus.write_data_L2_MEM, mk_line(8'h00));
    check_eq("t1_top",    512'(bus.write_data_L2_MEM[511:504]), 512'(8'h00));
    check_eq("t1_low",    512'(bus.write_data_L2_MEM[7:0]), 512'(8'h3F));
    check_eq("t1_tag",    512'(bus.tag_o), 512'(0));
    check_eq("t1_idx",    512'(bus.index_o), 512'(0));
    idle(20);
    check_eq("t1_hold",   512'(bus.write_L2_MEM), 512'(1));
    pulse_ready();
    check_eq("t1_wr_off", 512'(bus.write_L2_MEM), 512'(0));
    check_eq("t1_idx1",   512'(bus.index_o), 512'(1));
    check_eq("t1_lines",  512'(bus.lines_o), 512'(1));
    check_eq("t1_flags",  512'({bus.busy_o, bus.overflow_o, bus.timeout_o}), 512'(0));

    // 6: byte coincident with ready is dropped
    fill_line(8'h40);
    bus.din          = 8'h77;
    bus.din_valid    = 1'b1;
    bus.ready_MEM_L2 = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid    = 1'b0;
    bus.ready_MEM_L2 = 1'b0;
    check_eq("t6_wr_off", 512'(bus.write_L2_MEM), 512'(0));
    check_eq("t6_ovf",    512'(bus.overflow_o), 512'(1));
    check_eq("t6_idx",    512'(bus.index_o), 512'(2));
    fill_line(8'h80);
    check_eq("t6_data",   bus.write_data_L2_MEM, mk_line(8'h80));
    check_eq("t6_idx2",   512'(bus.index_o), 512'(2));
    pulse_ready();
    check_eq("t6_lines",  512'(bus.lines_o), 512'(3));

    // 2: long WRITE with bytes arriving
    fill_line(8'hC0);
    idle(100);
    send_byte(8'hFF);
    idle(100);
    send_byte(8'hEE);
    idle(100);
    send_byte(8'hDD);
    idle(197);
    check_eq("t2_wr",     512'(bus.write_L2_MEM), 512'(1));
    check_eq("t2_data",   bus.write_data_L2_MEM, mk_line(8'hC0));
    check_eq("t2_idx",    512'(bus.index_o), 512'(3));
    check_eq("t2_ovf",    512'(bus.overflow_o), 512'(1));
    check_eq("t2_to",     512'(bus.timeout_o), 512'(0));
    pulse_ready();
    check_eq("t2_wr_off", 512'(bus.write_L2_MEM), 512'(0));
    check_eq("t2_lines",  512'(bus.lines_o), 512'(4));

    // 3: partial line discarded after 100 idle cycles
    for (int k = 0; k < 10; k++) send_byte(8'hA0 + 8'(k));
    idle(99);
    check_eq("t3_to_early", 512'(bus.timeout_o), 512'(0));
    idle(1);
    check_eq("t3_to",     512'(bus.timeout_o), 512'(1));
    check_eq("t3_wr",     512'(bus.write_L2_MEM), 512'(0));
    check_eq("t3_idx",    512'(bus.index_o), 512'(4));
    fill_line(8'h20);
    check_eq("t3_data",   bus.write_data_L2_MEM, mk_line(8'h20));
    check_eq("t3_idx2",   512'(bus.index_o), 512'(4));
    pulse_ready();
    check_eq("t3_lines",  512'(bus.lines_o), 512'(5));

    // 4: 5-bit address wraps after 32 lines, lines_o after 16
    for (int i = 0; i < 11; i++) do_line(8'(i * 3));
    check_eq("t4_lines16", 512'(bus.lines_o), 512'(0));
    check_eq("t4_tag16",   512'(bus.tag_o), 512'(2));
    check_eq("t4_idx16",   512'(bus.index_o), 512'(0));
    for (int i = 0; i < 15; i++) do_line(8'(i * 5));
    check_eq("t4_lines31", 512'(bus.lines_o), 512'(15));
    check_eq("t4_tag31",   512'(bus.tag_o), 512'(3));
    check_eq("t4_idx31",   512'(bus.index_o), 512'(7));
    do_line(8'h33);
    check_eq("t4_lines0",  512'(bus.lines_o), 512'(0));
    check_eq("t4_tag0",    512'(bus.tag_o), 512'(0));
    check_eq("t4_idx0",    512'(bus.index_o), 512'(0));

    // 5: asynchronous reset during WRITE
    do_line(8'h10);
    fill_line(8'h55);
    check_eq("t5_idx_pre", 512'(bus.index_o), 512'(1));
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_eq("t5_wr",     512'(bus.write_L2_MEM), 512'(0));
    check_eq("t5_tag",    512'(bus.tag_o), 512'(0));
    check_eq("t5_idx",    512'(bus.index_o), 512'(0));
    check_eq("t5_flags",  512'({bus.busy_o, bus.overflow_o, bus.timeout_o}), 512'(0));
    check_eq("t5_lines",  512'(bus.lines_o), 512'(0));
    check_eq("t5_data",   bus.write_data_L2_MEM, 512'(0));
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(1);
    fill_line(8'h99);
    check_eq("t5_new_data", bus.write_data_L2_MEM, mk_line(8'h99));
    check_eq("t5_new_idx",  512'(bus.index_o), 512'(0));
    pulse_ready();
    check_eq("t5_new_idx1", 512'(bus.index_o), 512'(1));
    check_eq("t5_new_lines", 512'(bus.lines_o), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
